extractor_ring_ctrl: RTL and testbench
======================================

// Module: extractor_ring_ctrl
// PURPOSE
//  Job sequencer for extractor_ring. Accepts job descriptors (bitwidth, value count) and configures the ring.
//  Holds the ring in reset between jobs and meters input words into the ring.
//  Counts extracted output values and signals job completion. Ring data paths bypass this block;
//  only valid/ready handshakes pass through it or are monitored by it.
// PARAMETERS
//  DATA_W      16  ring input/output word width (bits)
//  CNT_W       32  width of value count and internal counters
//  CLR_CYCLES  2   cycles ring_rstn held low before each job (>=1)
// PORTS
//  clk             in   1       clock
//  rst             in   1       synchronous reset, active-high
//  job_valid       in   1       job descriptor valid
//  job_ready       out  1       controller can accept a job
//  job_bitwidth    in   5       bits per extracted value
//  job_count       in   CNT_W   number of values to extract
//  cfg_bitwidth    out  5       to ring bitwidth_d; stable from CLEAR to DONE
//  cfg_mask        out  DATA_W  to ring mask_valid_bits: (1<<bitwidth)-1; all ones when bitwidth==16
//  cfg_count       out  CNT_W   to ring transmitted_values
//  ring_rstn       out  1       active-low reset to ring
//  src_valid       in   1       upstream word valid
//  src_ready       out  1       upstream word ready
//  ring_rcv_valid  out  1       gated valid to ring
//  ring_rcv_ready  in   1       ring rcv_ready
//  ring_trm_valid  in   1       ring trm_valid (monitored)
//  ring_trm_ready  in   1       downstream trm_ready (monitored)
//  busy            out  1       high in CLEAR and RUN
//  done            out  1       1-cycle pulse at job end
//  err             out  1       1-cycle pulse on rejected job
// BEHAVIOUR
//  Reset (rst=1): state=IDLE; job_ready=0 during reset, 1 from first cycle after.
//    ring_rstn=0; cfg_*=0; done=err=busy=0; src_ready=ring_rcv_valid=0; counters=0.
//  Job accept: job_valid && job_ready, IDLE only; job_ready=1 only in IDLE.
//  Legal job: 1<=bitwidth<=16 and count!=0.
//    Illegal: err=1 next cycle, stay IDLE, cfg_* unchanged.
//  IDLE -> CLEAR on legal accept.
//    Latch cfg_*, out_left=count, in_left=ceil(count*bitwidth/DATA_W).
//    in_left is computed from a CNT_W+5 bit product and is registered.
//  CLEAR: ring_rstn=0 for exactly CLR_CYCLES cycles, then -> RUN. ring_rstn=1 only in RUN.
//  RUN: ring_rcv_valid = src_valid && (in_left!=0); src_ready = ring_rcv_ready && (in_left!=0).
//    in_left-- on ring_rcv_valid && ring_rcv_ready.
//    out_left-- on ring_trm_valid && ring_trm_ready.
//    Both may decrement in the same cycle; they are independent.
//    Once in_left==0, excess upstream words are stalled (src_ready=0) and never dropped.
//  RUN -> DONE when out_left transitions 1->0.
//  DONE: one cycle; done=1; ring_rstn=0. -> IDLE; job_ready=1 the following cycle.
//  Earliest back-to-back job accept: 2 cycles after done.
//  Ring outputs outside RUN are ignored; counters are not decremented.
//  rst mid-job: job abandoned immediately; no done pulse; ring_rstn=0 the next cycle.
// CONFIGURATION
//  EXTRACTOR_CTRL_PERF_CNT_EN defined:
//    adds outputs perf_active_cycles [31:0] and perf_stall_cycles [31:0].
//    perf_active_cycles counts RUN cycles.
//    perf_stall_cycles counts RUN cycles with ring_trm_valid && !ring_trm_ready.
//    Both are cleared on accept of a new legal job and on rst; they saturate at all ones.
//    Values are held after DONE until the next job.
//  Macro undefined: ports absent; behaviour otherwise identical.
// TESTING
//  T1 bitwidth=4, count=32, src words 16'h4321 always valid, trm_ready=1
//     -> exactly 8 words accepted, 32 output beats, done 1 cycle, job_ready back to 1.
//  T2 bitwidth=5, count=7 -> in_left=3 (35 bits); 4th src word stalled with src_ready=0; done after 7 beats.
//  T3 bitwidth=0, then bitwidth=17, each with count=8 -> err pulse each time, no CLEAR, ring_rstn stays 0.
//  T4 bitwidth=4, count=32; trm_ready=0 for 4 cycles mid-run -> out_left frozen; done after 32 beats total;
//     perf_stall_cycles=4 with EXTRACTOR_CTRL_PERF_CNT_EN.
//  T5 rst=1 for 1 cycle after 10 output beats -> IDLE, no done; next job of count=32 completes with 32 beats.
//  T6 bitwidth=16, count=3 -> cfg_mask=16'hFFFF, 3 words in, 3 beats out; second job accepted 2 cycles after done.

Source files
------------

// File: rtl/extractor_ring_ctrl.sv
// Job sequencer for extractor_ring: accepts job descriptors, configures and resets the ring, meters input
// words into it and counts extracted values. Optional EXTRACTOR_CTRL_PERF_CNT_EN adds run/stall counters.
module extractor_ring_ctrl #(
    parameter int DATA_W     = 16,
    parameter int CNT_W      = 32,
    parameter int CLR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [4:0]        job_bitwidth,
    input  logic [CNT_W-1:0]  job_count,
    output logic [4:0]        cfg_bitwidth,
    output logic [DATA_W-1:0] cfg_mask,
    output logic [CNT_W-1:0]  cfg_count,
    output logic              ring_rstn,
    input  logic              src_valid,
    output logic              src_ready,
    output logic              ring_rcv_valid,
    input  logic              ring_rcv_ready,
    input  logic              ring_trm_valid,
    input  logic              ring_trm_ready,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef EXTRACTOR_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]       perf_active_cycles,
    output logic [31:0]       perf_stall_cycles
`endif
);
    // Handshakes: a transfer happens on a rising clk edge where valid && ready; valid never waits on ready.

    localparam int PROD_W = CNT_W + 5;
    localparam int CLR_W  = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PROD_W-1:0]   in_left;
    logic [CNT_W-1:0]    out_left;
    logic [CLR_W-1:0]    clr_cnt;
    logic [PROD_W-1:0]   prod;
    logic [PROD_W-1:0]   in_left_init;
    logic [DATA_W-1:0]   mask_nxt;
    logic                accept;
    logic                legal;
    logic                run;
    logic                in_live;
    logic                in_take;
    logic                out_take;

    // in_left keeps the full product width: the rounded-up sum cannot overflow CNT_W+5 bits.
    assign prod         = PROD_W'(job_count) * PROD_W'(job_bitwidth);
    assign in_left_init = (prod + PROD_W'(DATA_W - 1)) / PROD_W'(DATA_W);

    assign run       = (state == S_RUN);
    assign job_ready = (state == S_IDLE) && !rst;
    assign accept    = job_valid && job_ready;
    assign legal     = (job_bitwidth != 5'd0) && (job_bitwidth <= 5'd16) && (job_count != '0);
    assign in_live   = (in_left != '0);

    assign ring_rcv_valid = run && src_valid && in_live;
    assign src_ready      = run && ring_rcv_ready && in_live;
    assign in_take        = ring_rcv_valid && ring_rcv_ready;
    assign out_take       = run && ring_trm_valid && ring_trm_ready;

    assign ring_rstn = run;
    assign busy      = (state == S_CLEAR) || run;
    assign done      = (state == S_DONE);

    always_comb begin
        mask_nxt = '0;
        for (int i = 0; i < DATA_W; i++) begin
            mask_nxt[i] = (i < int'(job_bitwidth));
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && legal) state_nxt = S_CLEAR;
            S_CLEAR: if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) state_nxt = S_RUN;
            S_RUN:   if (out_take && (out_left == CNT_W'(1))) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cfg_bitwidth <= '0;
            cfg_mask     <= '0;
            cfg_count    <= '0;
            in_left      <= '0;
            out_left     <= '0;
            clr_cnt      <= '0;
            err          <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= accept && !legal;
            if (accept && legal) begin
                cfg_bitwidth <= job_bitwidth;
                cfg_mask     <= mask_nxt;
                cfg_count    <= job_count;
                in_left      <= in_left_init;
                out_left     <= job_count;
                clr_cnt      <= '0;
            end
            if (state == S_CLEAR) clr_cnt <= clr_cnt + CLR_W'(1);
            if (in_take) in_left <= in_left - PROD_W'(1);
            if (out_take) out_left <= out_left - CNT_W'(1);
        end
    end

`ifdef EXTRACTOR_CTRL_PERF_CNT_EN
    // Counters saturate and hold their value after DONE until the next legal job clears them.
    always_ff @(posedge clk) begin
        if (rst || (accept && legal)) begin
            perf_active_cycles <= '0;
            perf_stall_cycles  <= '0;
        end else if (run) begin
            if (perf_active_cycles != '1) perf_active_cycles <= perf_active_cycles + 32'd1;
            if (ring_trm_valid && !ring_trm_ready && (perf_stall_cycles != '1))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_extractor_ring_ctrl.sv
// Self-checking bench for extractor_ring_ctrl: directed job scenarios plus randomized jobs, a bit-bucket
// ring model and a scoreboard monitor. Perf counter checks apply when EXTRACTOR_CTRL_PERF_CNT_EN is defined.
module tb_extractor_ring_ctrl;
    localparam int DATA_W     = 16;
    localparam int CNT_W      = 32;
    localparam int CLR_CYCLES = 2;

    logic              clk;
    logic              rst;
    logic              job_valid;
    logic              job_ready;
    logic [4:0]        job_bitwidth;
    logic [CNT_W-1:0]  job_count;
    logic [4:0]        cfg_bitwidth;
    logic [DATA_W-1:0] cfg_mask;
    logic [CNT_W-1:0]  cfg_count;
    logic              ring_rstn;
    logic              src_valid;
    logic              src_ready;
    logic              ring_rcv_valid;
    logic              ring_rcv_ready;
    logic              ring_trm_valid;
    logic              ring_trm_ready;
    logic              busy;
    logic              done;
    logic              err;
`ifdef EXTRACTOR_CTRL_PERF_CNT_EN
    logic [31:0]       perf_active_cycles;
    logic [31:0]       perf_stall_cycles;
`endif

    extractor_ring_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .CLR_CYCLES(CLR_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_bitwidth(job_bitwidth), .job_count(job_count),
        .cfg_bitwidth(cfg_bitwidth), .cfg_mask(cfg_mask), .cfg_count(cfg_count),
        .ring_rstn(ring_rstn),
        .src_valid(src_valid), .src_ready(src_ready),
        .ring_rcv_valid(ring_rcv_valid), .ring_rcv_ready(ring_rcv_ready),
        .ring_trm_valid(ring_trm_valid), .ring_trm_ready(ring_trm_ready),
        .busy(busy), .done(done), .err(err)
`ifdef EXTRACTOR_CTRL_PERF_CNT_EN
        , .perf_active_cycles(perf_active_cycles), .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    typedef struct {
        int     bw;
        longint cnt;
        longint words;
    } job_t;

    job_t       job_q[$];
    logic [0:0] err_q[$];
    int         total = 0;
    int         bad = 0;

    function automatic void check(string name, longint act, longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- ring model / driver ----------------
    int cur_bw = 1;
    int bits = 0;
    bit rand_mode = 0;
    int stall_left = 0;

    initial begin
        src_valid = 0;
        ring_rcv_ready = 0;
        ring_trm_valid = 0;
        ring_trm_ready = 0;
        forever begin
            @(posedge clk);
            #1;
            src_valid = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (ring_rstn) begin
                ring_rcv_ready = (bits < 48) && (rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
                ring_trm_valid = (bits >= cur_bw) && (rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1);
            end else begin
                ring_rcv_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
                ring_trm_valid = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (stall_left > 0) begin
                ring_trm_ready = 1'b0;
                stall_left--;
            end else begin
                ring_trm_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    job_t   cur;
    bit     in_job = 0;
    bit     run_seen = 0;
    bit     done_due = 0;
    bit     ready_due = 0;
    bit     prev_busy = 0;
    longint words = 0;
    longint beats = 0;
    int     clr_cyc = 0;
    int     active_seen = 0;
    int     stall_seen = 0;
    int     last_stall = 0;
    int     done_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            check("job_ready_in_rst", job_ready, 0);
            in_job = 0;
            done_due = 0;
            ready_due = 0;
            prev_busy = 0;
            bits = 0;
            job_q.delete();
            err_q.delete();
        end else begin
            if (err_q.size() > 0) begin
                void'(err_q.pop_front());
                check("err_pulse", err, 1);
            end else begin
                check("err_idle", err, 0);
            end
            if (ready_due) check("job_ready_after_done", job_ready, 1);
            ready_due = 0;
            if (busy) check("job_ready_busy", job_ready, 0);
            check("done_timing", done, done_due);
            done_due = 0;
            if (done) begin
                check("done_busy", busy, 0);
                if (in_job) begin
                    check("words_in", words, cur.words);
                    check("beats_out", beats, cur.cnt);
`ifdef EXTRACTOR_CTRL_PERF_CNT_EN
                    check("perf_active", perf_active_cycles, active_seen);
                    check("perf_stall", perf_stall_cycles, stall_seen);
`endif
                end
                last_stall = stall_seen;
                in_job = 0;
                done_cnt++;
                ready_due = 1;
            end
            if (busy && !prev_busy) begin
                if (job_q.size() == 0) begin
                    check("unexpected_job_start", 1, 0);
                end else begin
                    logic [31:0] m;
                    cur = job_q.pop_front();
                    m = (32'd1 << cur.bw) - 32'd1;
                    check("cfg_bitwidth", cfg_bitwidth, cur.bw);
                    check("cfg_mask", cfg_mask, m[15:0]);
                    check("cfg_count", cfg_count, cur.cnt);
                    in_job = 1;
                    run_seen = 0;
                    words = 0;
                    beats = 0;
                    clr_cyc = 0;
                    active_seen = 0;
                    stall_seen = 0;
                end
            end
            if (in_job) begin
                if (busy && !ring_rstn) clr_cyc++;
                if (ring_rstn && !run_seen) begin
                    run_seen = 1;
                    check("clear_len", clr_cyc, CLR_CYCLES);
                end
                if (ring_rstn) begin
                    active_seen++;
                    if (ring_trm_valid && !ring_trm_ready) stall_seen++;
                    check("rcv_valid_run", ring_rcv_valid, src_valid && (words < cur.words));
                    if (words >= cur.words) check("src_stall", src_ready, 0);
                    if (src_valid && src_ready) begin
                        words++;
                        bits += DATA_W;
                    end
                    if (ring_trm_valid && ring_trm_ready) begin
                        beats++;
                        bits -= cur.bw;
                        if (beats == cur.cnt) done_due = 1;
                    end
                end
            end
            if (!ring_rstn) begin
                check("src_ready_gated", src_ready, 0);
                check("rcv_valid_gated", ring_rcv_valid, 0);
                bits = 0;
            end
            prev_busy = busy;
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic submit(input int bw, input longint cnt, output int waited);
        bit got;
        got = 0;
        waited = 0;
        @(posedge clk);
        #2;
        job_valid = 1'b1;
        job_bitwidth = 5'(bw);
        job_count = 32'(cnt);
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            waited++;
            if (job_ready) got = 1;
        end
        @(posedge clk);
        #2;
        job_valid = 1'b0;
        check("job_accept", got, 1);
        if (got) begin
            if (bw >= 1 && bw <= 16 && cnt != 0) begin
                job_t j;
                j.bw = bw;
                j.cnt = cnt;
                j.words = (cnt * bw + DATA_W - 1) / DATA_W;
                cur_bw = bw;
                job_q.push_back(j);
            end else begin
                err_q.push_back(1'b1);
            end
        end
    endtask

    task automatic wait_done();
        int start;
        bit seen;
        start = done_cnt;
        seen = 0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge clk);
            if (done_cnt != start) seen = 1;
        end
        check("done_reached", seen, 1);
    endtask

    task automatic wait_beats(input longint n);
        bit seen;
        seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (in_job && beats >= n) seen = 1;
        end
        check("beats_reached", seen, 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int w;
        int bw;
        longint cnt;
        int r;
        rst = 1'b1;
        job_valid = 1'b0;
        job_bitwidth = '0;
        job_count = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ring_rstn", ring_rstn, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_cfg_bitwidth", cfg_bitwidth, 0);
        check("rst_cfg_mask", cfg_mask, 0);
        check("rst_cfg_count", cfg_count, 0);
        check("rst_src_ready", src_ready, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("job_ready_after_rst", job_ready, 1);

        // T1: 4-bit values, 32 of them -> 8 words
        submit(4, 32, w);
        wait_done();

        // T3: illegal bitwidths leave config and ring untouched
        submit(0, 8, w);
        repeat (3) @(negedge clk);
        submit(17, 8, w);
        repeat (3) @(negedge clk);
        check("illegal_cfg_bitwidth_held", cfg_bitwidth, 4);
        check("illegal_cfg_count_held", cfg_count, 32);
        check("illegal_ring_rstn", ring_rstn, 0);
        check("illegal_busy", busy, 0);

        // T2: 35 bits need 3 words; the 4th upstream word must stall
        submit(5, 7, w);
        wait_done();

        // T4: downstream stall of 4 cycles mid-run
        submit(4, 32, w);
        wait_beats(10);
        stall_left = 4;
        wait_done();
        check("t4_stall_cycles", last_stall, 4);
`ifdef EXTRACTOR_CTRL_PERF_CNT_EN
        repeat (2) @(negedge clk);
        check("t4_perf_stall_held", perf_stall_cycles, 4);
`endif

        // T5: reset mid-job, then a full job
        submit(4, 32, w);
        wait_beats(10);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("t5_busy_after_rst", busy, 0);
        check("t5_ring_rstn_after_rst", ring_rstn, 0);
        check("t5_no_done", done, 0);
        check("t5_job_ready", job_ready, 1);
        submit(4, 32, w);
        wait_done();

        // T6: full-width values and back-to-back jobs
        submit(16, 3, w);
        wait_done();
        submit(16, 3, w);
        check("t6_b2b_accept_within_2", (w <= 2), 1);
        wait_done();

        // randomized jobs with random handshakes and ring noise outside RUN
        rand_mode = 1;
        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(0, 9);
            bw = $urandom_range(1, 16);
            cnt = $urandom_range(1, 40);
            if (r == 0) bw = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(17, 31);
            if (r == 1) cnt = 0;
            submit(bw, cnt, w);
            if (bw >= 1 && bw <= 16 && cnt != 0) wait_done();
            else repeat (2) @(negedge clk);
        end
        rand_mode = 0;

        repeat (5) @(negedge clk);
        check("job_q_drained", job_q.size(), 0);
        check("err_q_drained", err_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
